// File: rtl/alu_rr_sched_if.sv
// alu_rr_sched_if: bundle of the two request channels, the shared-ALU
// connection and the response channel of alu_rr_sched.
//   slave  : scheduler view (takes requests, drives ALU operands, returns responses)
//   master : environment view (requesters, ALU, response consumer)
interface alu_rr_sched_if #(
  parameter int unsigned DW = 4
);
  localparam int unsigned OPW = 3;
  localparam int unsigned FW  = 4;

  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;

  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_y;
  logic [FW-1:0]  alu_flags;   // {carry, overflow, zero, equal}

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [DW-1:0]  rsp_y;
  logic [FW-1:0]  rsp_flags;

  logic           busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_y, alu_flags,
    output rsp_valid, rsp_id, rsp_y, rsp_flags,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_y, alu_flags,
    input  rsp_valid, rsp_id, rsp_y, rsp_flags,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one combinational ALU between
// two requesters. One operation in flight: IDLE (accept) -> EXEC (ALU
// evaluates latched operands) -> RESP (hold result until consumed).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_rr_sched_if.slave -- req0/req1 valid/ready channels,
//          registered alu_op/alu_a/alu_b, alu_y/alu_flags in,
//          rsp valid/ready channel with id/y/flags, busy
module alu_rr_sched #(
  parameter int unsigned DW = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_rr_sched_if.slave  bus
);
  localparam int unsigned OPW = 3;
  localparam int unsigned FW  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           prio_q;
  logic           grant_c;
  logic           accept_c;
  logic           req0_ready_c;
  logic           req1_ready_c;

  logic [OPW-1:0] alu_op_q;
  logic [DW-1:0]  alu_a_q;
  logic [DW-1:0]  alu_b_q;
  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [DW-1:0]  rsp_y_q;
  logic [FW-1:0]  rsp_flags_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, grant and readies; a lone requester always wins, contention
  // goes to prio. Readies are suppressed while rst is high.
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    grant_c      = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;

    if (bus.req0_valid && bus.req1_valid) grant_c = prio_q;
    else                                  grant_c = bus.req1_valid;

    case (state_q)
      IDLE: begin
        if (!rst && (bus.req0_valid || bus.req1_valid)) begin
          accept_c = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req0_ready_c = accept_c && !grant_c;
    req1_ready_c = accept_c &&  grant_c;
  end

  // Operand latch on acceptance, result capture in EXEC, response hold in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      if (accept_c) begin
        if (grant_c) begin
          alu_op_q <= bus.req1_op;
          alu_a_q  <= bus.req1_a;
          alu_b_q  <= bus.req1_b;
        end else begin
          alu_op_q <= bus.req0_op;
          alu_a_q  <= bus.req0_a;
          alu_b_q  <= bus.req0_b;
        end
        rsp_id_q <= grant_c;
        prio_q   <= !grant_c;  // loser of this round gets preference next
      end
      if (state_q == EXEC) begin
        rsp_y_q     <= bus.alu_y;
        rsp_flags_q <= bus.alu_flags;
        rsp_valid_q <= 1'b1;
      end else if ((state_q == RESP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = req0_ready_c;
  assign bus.req1_ready = req1_ready_c;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: directed bench for alu_rr_sched. Provides a small stub ALU
// (add, and, equal) and walks reset, single op, contention, backpressure,
// reset mid-operation and lone-requester sequences with hand-computed values.
module tb_alu_rr_sched;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  alu_rr_sched_if #(.DW(4)) bus ();

  alu_rr_sched #(.DW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: 000 add, 011 and, 111 equal; flags {carry, overflow, zero, equal}
  always_comb begin
    logic [4:0] sum;
    sum           = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    bus.alu_y     = 4'h0;
    bus.alu_flags = 4'h0;
    case (bus.alu_op)
      3'b000: begin
        bus.alu_y     = sum[3:0];
        bus.alu_flags = {sum[4],
                         (bus.alu_a[3] == bus.alu_b[3]) && (sum[3] != bus.alu_a[3]),
                         (sum[3:0] == 4'h0), 1'b0};
      end
      3'b011: bus.alu_y = bus.alu_a & bus.alu_b;
      3'b111: bus.alu_flags = {3'b000, bus.alu_a == bus.alu_b};
      default: ;
    endcase
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic e0, input logic e1);
    cmp({tag, ".req0_ready"}, 8'(bus.req0_ready), 8'(e0));
    cmp({tag, ".req1_ready"}, 8'(bus.req1_ready), 8'(e1));
  endtask

  task automatic chk_rsp(input string tag, input logic ev, input logic eid,
                         input logic [3:0] ey, input logic [3:0] ef, input logic eb);
    cmp({tag, ".rsp_valid"}, 8'(bus.rsp_valid), 8'(ev));
    cmp({tag, ".rsp_id"},    8'(bus.rsp_id),    8'(eid));
    cmp({tag, ".rsp_y"},     8'(bus.rsp_y),     8'(ey));
    cmp({tag, ".rsp_flags"}, 8'(bus.rsp_flags), 8'(ef));
    cmp({tag, ".busy"},      8'(bus.busy),      8'(eb));
  endtask

  task automatic chk_alu(input string tag, input logic [2:0] eop,
                         input logic [3:0] ea, input logic [3:0] eb);
    cmp({tag, ".alu_op"}, 8'(bus.alu_op), 8'(eop));
    cmp({tag, ".alu_a"},  8'(bus.alu_a),  8'(ea));
    cmp({tag, ".alu_b"},  8'(bus.alu_b),  8'(eb));
  endtask

  logic [2:0] lop [3];
  logic [3:0] la  [3];
  logic [3:0] lb  [3];
  logic [3:0] ly  [3];
  logic [3:0] lf  [3];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    lop[0] = 3'b011; la[0] = 4'hF; lb[0] = 4'h6; ly[0] = 4'h6; lf[0] = 4'h0;
    lop[1] = 3'b000; la[1] = 4'h8; lb[1] = 4'h8; ly[1] = 4'h0; lf[1] = 4'hE;
    lop[2] = 3'b111; la[2] = 4'h5; lb[2] = 4'h4; ly[2] = 4'h0; lf[2] = 4'h0;

    // Reset with req0 already valid
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'h3; bus.req0_b = 4'h5;
    bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = 4'h0; bus.req1_b = 4'h0;
    bus.rsp_ready  = 1'b1;
    nxt(); smp();
    chk_rdy("rst_a", 1'b0, 1'b0);
    chk_rsp("rst_a", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    chk_alu("rst_a", 3'b000, 4'h0, 4'h0);
    nxt(); smp();
    chk_rdy("rst_b", 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_rdy("post_rst", 1'b1, 1'b0);

    // Single add 3+5
    nxt(); bus.req0_valid = 1'b0; smp();
    chk_rdy("add_exec", 1'b0, 1'b0);
    chk_rsp("add_exec", 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk_alu("add_exec", 3'b000, 4'h3, 4'h5);
    nxt(); smp();
    chk_rsp("add_resp", 1'b1, 1'b0, 4'h8, 4'h4, 1'b1);
    chk_rdy("add_resp", 1'b0, 1'b0);
    nxt(); smp();
    chk_rsp("add_done", 1'b0, 1'b0, 4'h8, 4'h4, 1'b0);
    chk_alu("alu_hold", 3'b000, 4'h3, 4'h5);

    // Contention after a fresh reset: grants 0,1,0,1
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'b011; bus.req0_a = 4'hC; bus.req0_b = 4'hA;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b111; bus.req1_a = 4'h9; bus.req1_b = 4'h9;
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = (k % 2) == 1;
      smp();
      chk_rdy("cont_idle", !g, g);
      nxt(); smp();
      chk_rdy("cont_exec", 1'b0, 1'b0);
      chk_alu("cont_exec", g ? 3'b111 : 3'b011, g ? 4'h9 : 4'hC, g ? 4'h9 : 4'hA);
      nxt(); smp();
      chk_rsp("cont_resp", 1'b1, g, g ? 4'h0 : 4'h8, g ? 4'h1 : 4'h0, 1'b1);
      chk_rdy("cont_resp", 1'b0, 1'b0);
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      nxt();
    end

    // Backpressure: F+1 held in RESP while req1 waits
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'hF; bus.req0_b = 4'h1;
    bus.rsp_ready  = 1'b0;
    smp();
    chk_rdy("bp_idle", 1'b1, 1'b0);
    nxt();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b111; bus.req1_a = 4'h2; bus.req1_b = 4'h3;
    smp();
    chk_rdy("bp_exec", 1'b0, 1'b0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      smp();
      chk_rsp("bp_hold", 1'b1, 1'b0, 4'h0, 4'hA, 1'b1);
      chk_rdy("bp_hold", 1'b0, 1'b0);
      nxt();
    end
    bus.rsp_ready = 1'b1;
    smp();
    chk_rsp("bp_last", 1'b1, 1'b0, 4'h0, 4'hA, 1'b1);
    nxt(); smp();
    chk_rsp("bp_release", 1'b0, 1'b0, 4'h0, 4'hA, 1'b0);
    chk_rdy("bp_release", 1'b0, 1'b1);
    nxt();
    bus.req1_valid = 1'b0;
    smp();
    chk_alu("bp_next", 3'b111, 4'h2, 4'h3);
    nxt(); smp();
    chk_rsp("bp_next_resp", 1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
    nxt();

    // Reset during EXEC
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'h1; bus.req0_b = 4'h1;
    smp();
    chk_rdy("mid_idle", 1'b1, 1'b0);
    nxt();
    bus.req0_valid = 1'b0;
    smp();
    chk_rsp("mid_exec", 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    smp();
    chk_rsp("rst_exec", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    chk_alu("rst_exec", 3'b000, 4'h0, 4'h0);
    nxt(); smp();
    chk_rsp("rst_exec_norsp", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

    // Reset during RESP, taking priority over the handshake
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'h2; bus.req0_b = 4'h2;
    #1;
    chk_rdy("mid2_idle", 1'b1, 1'b0);
    nxt();
    bus.req0_valid = 1'b0;
    nxt(); smp();
    chk_rsp("mid2_resp", 1'b1, 1'b0, 4'h4, 4'h0, 1'b1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b000; bus.req1_a = 4'h7; bus.req1_b = 4'h1;
    smp();
    chk_rsp("rst_resp", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    chk_rdy("prio_after_rst", 1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    #1;
    chk_rdy("req1_after_rst", 1'b0, 1'b1);
    nxt();
    bus.req1_op = lop[0]; bus.req1_a = la[0]; bus.req1_b = lb[0];
    smp();
    chk_alu("req1_after_rst", 3'b000, 4'h7, 4'h1);
    chk_rdy("req1_after_rst_exec", 1'b0, 1'b0);
    nxt(); smp();
    chk_rsp("req1_after_rst", 1'b1, 1'b1, 4'h8, 4'h4, 1'b1);
    nxt();

    // Lone requester: three back-to-back req1 ops
    for (int j = 0; j < 3; j++) begin
      smp();
      chk_rdy("lone_idle", 1'b0, 1'b1);
      nxt();
      if (j < 2) begin
        bus.req1_op = lop[j+1]; bus.req1_a = la[j+1]; bus.req1_b = lb[j+1];
      end else begin
        bus.req1_valid = 1'b0;
      end
      smp();
      chk_alu("lone_exec", lop[j], la[j], lb[j]);
      chk_rdy("lone_exec", 1'b0, 1'b0);
      nxt(); smp();
      chk_rsp("lone_resp", 1'b1, 1'b1, ly[j], lf[j], 1'b1);
      nxt();
    end
    smp();
    chk_rsp("end_idle", 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
    chk_rdy("end_idle", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Round-robin scheduler that shares one combinational 4-bit ALU between two requesters.
- Accepts operations over valid/ready handshakes and holds them in registers.
- Drives the shared ALU from those registers, captures the result and flags, and returns them over a single response channel tagged with the requester id.
- Sits between two client blocks and the ALU's op/a/b inputs and y/flag outputs.

## Interface
- DW, 4, operand/result width; must equal the ALU width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  3  ALU op code (000 add … 111 equal).
- req0_a  in  DW  operand a.
- req0_b  in  DW  operand b.
- req1_valid / req1_ready / req1_op / req1_a / req1_b: same as requester 0, for requester 1.
- alu_op  out  3  op to shared ALU (registered).
- alu_a  out  DW  operand a to ALU (registered).
- alu_b  out  DW  operand b to ALU (registered).
- alu_y  in  DW  ALU result.
- alu_flags  in  4  ALU flags packed {carry, overflow, zero, equal}.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the op.
- rsp_y  out  DW  captured result.
- rsp_flags  out  4  captured flags, same packing as alu_flags.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. One operation in flight at a time.
- IDLE:
  - Grant logic: if exactly one requester is valid, grant it. If both are valid, grant the one selected by priority bit prio (0 = req0).
  - reqN_ready = (state == IDLE) && granted N. Ready is combinational on both valids. Requesters must not make valid depend on ready.
  - On valid && ready: latch op/a/b into alu_op/alu_a/alu_b, latch id, set prio to the id that was not granted, go to EXEC.
- EXEC: ALU evaluates the latched operands. At the clock edge, capture alu_y → rsp_y and alu_flags → rsp_flags, then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id/rsp_y/rsp_flags stay stable.
  - On rsp_ready, go to IDLE.
  - While rsp_valid && !rsp_ready, hold everything. Both readies stay 0.
- alu_op/alu_a/alu_b change only on acceptance; they hold their last value in IDLE.
- No arithmetic is done in this block. Results and flags pass through unmodified.
- Fairness: under continuous requests from both sides, grants strictly alternate.
- A lone requester is served back-to-back regardless of prio.

## Timing
- Reset values: state IDLE, prio 0, alu_op/alu_a/alu_b 0, rsp_valid 0, rsp_id 0, rsp_y 0, rsp_flags 0, busy 0.
- Readies are 0 during reset.
- Latency: acceptance at edge T → EXEC during cycle T+1 → rsp_valid high from cycle T+2.
- Minimum occupancy is 3 cycles per operation: accept cycle, EXEC cycle, RESP cycle with rsp_ready=1.
- The next acceptance is possible in the cycle after the RESP handshake.
- rst asserted in any state: next cycle returns to reset values. An in-flight operation is dropped and no response is produced.
- rst has priority over a simultaneous handshake.
- If valid is deasserted in IDLE without acceptance, nothing happens and prio is unchanged.
- If both requesters are valid while prio=1, req1 is granted and prio becomes 0.

## Test plan
- Reset: hold rst for 2 cycles with req0_valid=1 → req0_ready=0 during reset, all outputs equal reset values. The first cycle after reset: req0_ready=1.
- Single add: req0 op=000 a=3 b=5, rsp_ready=1 → req0_ready=1 in the accept cycle. rsp_valid is high 2 cycles later with rsp_id=0, rsp_y=8, rsp_flags=4'b0100, busy=1 during EXEC and RESP.
- Contention: both valid continuously, req0 op=011 a=C b=A, req1 op=111 a=9 b=9 → grants ordered 0,1,0,1. Responses alternate: (id0, y=8, flags 0000) then (id1, y=0, flags 0001). No acceptance occurs closer than 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_id/rsp_y/rsp_flags stay constant and both readies stay 0. Raise rsp_ready → IDLE next cycle, and a pending request is accepted in that cycle.
- Reset mid-operation: assert rst during EXEC, then during RESP → rsp_valid=0 the next cycle, prio=0, no response emitted. A subsequent req1-only request is still served normally.
- Lone requester: req1 valid for 3 back-to-back ops with req0 idle → all three are granted to req1, with acceptances every 3 cycles.
